// File: rtl/dram_controller.sv
// FPM DRAM sequencer for the 68000 DRAM window: multiplexed RAS/CAS accesses with
// per-byte CAS lanes, DTACK generation, and CAS-before-RAS refresh arbitration.
module dram_controller #(
    parameter int ADDR_W           = 10,
    parameter int REFRESH_CYCLES   = 390,
    parameter int CAS_CYCLES       = 2,
    parameter int RAS_REF_CYCLES   = 3,
    parameter int PRECHARGE_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                CS_DRAM_n,
    input  logic                AS_n,
    input  logic                UDS_n,
    input  logic                LDS_n,
    input  logic                RW,
    input  logic [2*ADDR_W-1:0] ADDR,
    output logic [ADDR_W-1:0]   DRAM_ADDR,
    output logic                RAS_n,
    output logic                CASU_n,
    output logic                CASL_n,
    output logic                WE_n,
    output logic                DTACK_DRAM_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_RAS, S_MUX, S_CAS, S_PRE, S_REF_CAS, S_REF_RAS
    } state_t;

    localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int MAX_DWELL =
        (CAS_CYCLES > RAS_REF_CYCLES)
            ? ((CAS_CYCLES > PRECHARGE_CYCLES) ? CAS_CYCLES : PRECHARGE_CYCLES)
            : ((RAS_REF_CYCLES > PRECHARGE_CYCLES) ? RAS_REF_CYCLES : PRECHARGE_CYCLES);
    localparam int CNT_W = $clog2(MAX_DWELL + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAS_LAST = CNT_W'(CAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(RAS_REF_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRECHARGE_CYCLES - 1);

    state_t              state, state_next;
    logic [TMR_W-1:0]    timer;
    logic [1:0]          pending, pending_next;
    logic [CNT_W-1:0]    dwell, dwell_next;
    logic [2*ADDR_W-1:0] addr_q;
    logic                uds_q, lds_q, rw_q;
    logic                tick, request, refresh_due;
    logic [ADDR_W-1:0]   dram_addr_next;
    logic                ras_next, casu_next, casl_next, we_next, dtack_next;

    assign tick        = (timer == TMR_LAST);
    assign request     = !CS_DRAM_n && !AS_n && (!UDS_n || !LDS_n);
    // A tick on this very edge counts, so refresh wins over a simultaneous request.
    assign refresh_due = tick || (pending != 2'd0);

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (refresh_due)  state_next = S_REF_CAS;
                else if (request) state_next = S_RAS;
            end
            S_RAS:     state_next = S_MUX;
            S_MUX:     state_next = S_CAS;
            S_CAS:     if (dwell >= CAS_LAST && AS_n) state_next = S_PRE;
            S_PRE: begin
                if (dwell == PRE_LAST) begin
                    if (refresh_due)  state_next = S_REF_CAS;
                    else if (request) state_next = S_RAS;
                    else              state_next = S_IDLE;
                end
            end
            S_REF_CAS: state_next = S_REF_RAS;
            S_REF_RAS: if (dwell == REF_LAST) state_next = S_PRE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Dwell counter restarts on every state change and saturates while stalled in CAS.
    always_comb begin
        dwell_next = dwell;
        if (state_next != state)
            dwell_next = '0;
        else if (dwell != '1)
            dwell_next = dwell + CNT_W'(1);
    end

    always_comb begin
        pending_next = pending;
        if (state_next == S_REF_CAS) begin
            if (!tick) pending_next = pending - 2'd1;
        end else if (tick && pending != 2'd3) begin
            pending_next = pending + 2'd1;
        end
    end

    // Outputs are decoded from the state being entered, then registered.
    always_comb begin
        dram_addr_next = DRAM_ADDR;
        ras_next       = 1'b1;
        casu_next      = 1'b1;
        casl_next      = 1'b1;
        we_next        = 1'b1;
        dtack_next     = 1'b1;
        case (state_next)
            S_RAS: begin
                ras_next       = 1'b0;
                dram_addr_next = ADDR[2*ADDR_W-1:ADDR_W];
            end
            S_MUX: begin
                ras_next       = 1'b0;
                dram_addr_next = addr_q[ADDR_W-1:0];
                we_next        = rw_q;
            end
            S_CAS: begin
                ras_next   = 1'b0;
                casu_next  = uds_q;
                casl_next  = lds_q;
                we_next    = rw_q;
                dtack_next = 1'b0;
            end
            S_REF_CAS: begin
                casu_next = 1'b0;
                casl_next = 1'b0;
            end
            S_REF_RAS: begin
                ras_next  = 1'b0;
                casu_next = 1'b0;
                casl_next = 1'b0;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state        <= S_IDLE;
            timer        <= '0;
            pending      <= 2'd0;
            dwell        <= '0;
            addr_q       <= '0;
            uds_q        <= 1'b1;
            lds_q        <= 1'b1;
            rw_q         <= 1'b1;
            DRAM_ADDR    <= '0;
            RAS_n        <= 1'b1;
            CASU_n       <= 1'b1;
            CASL_n       <= 1'b1;
            WE_n         <= 1'b1;
            DTACK_DRAM_n <= 1'b1;
        end else begin
            state   <= state_next;
            timer   <= tick ? '0 : timer + TMR_W'(1);
            pending <= pending_next;
            dwell   <= dwell_next;
            if (state_next == S_RAS) begin
                addr_q <= ADDR;
                uds_q  <= UDS_n;
                lds_q  <= LDS_n;
                rw_q   <= RW;
            end
            DRAM_ADDR    <= dram_addr_next;
            RAS_n        <= ras_next;
            CASU_n       <= casu_next;
            CASL_n       <= casl_next;
            WE_n         <= we_next;
            DTACK_DRAM_n <= dtack_next;
        end
    end

endmodule

// File: tb/tb_dram_controller.sv
// Scoreboard bench for dram_controller: directed bus cycles push expected access and
// refresh events; a negedge monitor reconstructs events from the DRAM pins and compares.
module tb_dram_controller;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        CS_DRAM_n, AS_n, UDS_n, LDS_n, RW;
    logic [19:0] ADDR;
    logic [9:0]  DRAM_ADDR;
    logic        RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n;

    dram_controller dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .CS_DRAM_n    (CS_DRAM_n),
        .AS_n         (AS_n),
        .UDS_n        (UDS_n),
        .LDS_n        (LDS_n),
        .RW           (RW),
        .ADDR         (ADDR),
        .DRAM_ADDR    (DRAM_ADDR),
        .RAS_n        (RAS_n),
        .CASU_n       (CASU_n),
        .CASL_n       (CASL_n),
        .WE_n         (WE_n),
        .DTACK_DRAM_n (DTACK_DRAM_n)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        bit         is_ref;
        int         start;
        int         mid;
        int         stop;
        logic [9:0] row;
        logic [9:0] col;
        logic       casu;
        logic       casl;
        logic       we;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  cur;
    bit   active;
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    logic p_ras, p_casu, p_casl, p_dtack;

    // Rising edges since reset release; edge k of the DUT timer is cyc == k.
    always @(posedge CLK) begin
        if (!RST_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ras"},   RAS_n,        1);
        check({tag, "_casu"},  CASU_n,       1);
        check({tag, "_casl"},  CASL_n,       1);
        check({tag, "_we"},    WE_n,         1);
        check({tag, "_dtack"}, DTACK_DRAM_n, 1);
        check({tag, "_addr"},  DRAM_ADDR,    0);
    endtask

    task automatic expect_acc(input string tag, input int s, input int m, input int e,
                              input logic [9:0] r, input logic [9:0] c,
                              input logic u, input logic l, input logic w);
        ev_t ev;
        ev.tag = tag; ev.is_ref = 1'b0; ev.start = s; ev.mid = m; ev.stop = e;
        ev.row = r; ev.col = c; ev.casu = u; ev.casl = l; ev.we = w;
        exp_q.push_back(ev);
    endtask

    task automatic expect_ref(input string tag, input int s, input int m, input int e);
        ev_t ev;
        ev.tag = tag; ev.is_ref = 1'b1; ev.start = s; ev.mid = m; ev.stop = e;
        ev.row = '0; ev.col = '0; ev.casu = 1'b0; ev.casl = 1'b0; ev.we = 1'b1;
        exp_q.push_back(ev);
    endtask

    task automatic compare_event(input ev_t got);
        ev_t want;
        check("event_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check({want.tag, "_kind"},  got.is_ref, want.is_ref);
            check({want.tag, "_start"}, got.start,  want.start);
            check({want.tag, "_mid"},   got.mid,    want.mid);
            check({want.tag, "_stop"},  got.stop,   want.stop);
            check({want.tag, "_casu"},  got.casu,   want.casu);
            check({want.tag, "_casl"},  got.casl,   want.casl);
            check({want.tag, "_we"},    got.we,     want.we);
            if (!want.is_ref) begin
                check({want.tag, "_row"}, got.row, want.row);
                check({want.tag, "_col"}, got.col, want.col);
            end
        end
    endtask

    // Monitor: access = RAS falls with CAS high; refresh = CAS falls with RAS high.
    always @(negedge CLK) begin
        if (!RST_n) begin
            active  = 1'b0;
            p_ras   = 1'b1;
            p_casu  = 1'b1;
            p_casl  = 1'b1;
            p_dtack = 1'b1;
        end else begin
            if (p_ras && !RAS_n && CASU_n && CASL_n) begin
                active     = 1'b1;
                cur.is_ref = 1'b0;
                cur.start  = cyc;
                cur.row    = DRAM_ADDR;
            end
            if (p_casu && p_casl && (!CASU_n || !CASL_n) && RAS_n) begin
                active     = 1'b1;
                cur.is_ref = 1'b1;
                cur.start  = cyc;
                cur.casu   = CASU_n;
                cur.casl   = CASL_n;
                cur.we     = WE_n;
            end
            if (active && !cur.is_ref && cyc == cur.start + 1) begin
                cur.col = DRAM_ADDR;
                cur.we  = WE_n;
                check("mux_cas_high", {CASU_n, CASL_n}, 2'b11);
            end
            if (active && !cur.is_ref && p_dtack && !DTACK_DRAM_n) begin
                cur.mid  = cyc;
                cur.casu = CASU_n;
                cur.casl = CASL_n;
                check("cas_we_stable", WE_n, cur.we);
            end
            if (active && cur.is_ref && p_ras && !RAS_n)
                cur.mid = cyc;
            if (!DTACK_DRAM_n)
                check("dtack_needs_ras", RAS_n, 0);
            if (active && cur.is_ref)
                check("dtack_in_refresh", DTACK_DRAM_n, 1);
            if (active && !p_ras && RAS_n) begin
                active   = 1'b0;
                cur.stop = cyc;
                compare_event(cur);
            end
            p_ras   = RAS_n;
            p_casu  = CASU_n;
            p_casl  = CASL_n;
            p_dtack = DTACK_DRAM_n;
        end
    end

    task automatic idle_bus();
        CS_DRAM_n = 1'b1;
        AS_n      = 1'b1;
        UDS_n     = 1'b1;
        LDS_n     = 1'b1;
        RW        = 1'b1;
    endtask

    task automatic go_to(input int k);
        while (cyc < k) @(negedge CLK);
    endtask

    // Drive a request so that it is first sampled at edge n.
    task automatic request(input int n, input logic [19:0] a, input logic u, input logic l, input logic w);
        go_to(n - 1);
        CS_DRAM_n = 1'b0;
        AS_n      = 1'b0;
        UDS_n     = u;
        LDS_n     = l;
        RW        = w;
        ADDR      = a;
    endtask

    // Raise AS_n so it is first sampled high at edge r.
    task automatic release_at(input int r);
        go_to(r - 1);
        idle_bus();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        RST_n = 1'b1;
        ADDR  = '0;
        idle_bus();
        #1 RST_n = 1'b0;
        #2 check_reset_outputs("reset_init");
        repeat (2) @(negedge CLK);
        #2 RST_n = 1'b1;

        // Word read: row = ADDR[19:10], column = ADDR[9:0].
        expect_acc("word_read", 10, 12, 16, 10'h0A9, 10'h1F3, 1'b0, 1'b0, 1'b1);
        request(10, 20'h2A5F3, 1'b0, 1'b0, 1'b1);
        release_at(16);

        // Byte write with LDS_n arriving one clock after AS_n.
        expect_acc("byte_write", 31, 33, 41, 10'h048, 10'h345, 1'b1, 1'b0, 1'b0);
        go_to(29);
        CS_DRAM_n = 1'b0; AS_n = 1'b0; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b0; ADDR = 20'h12345;
        go_to(30);
        check("late_lds_no_ras", RAS_n, 1);
        LDS_n = 1'b0;
        release_at(41);

        // Back-to-back: second RAS waits out the precharge.
        expect_acc("b2b_first",  60, 62, 66, 10'h152, 10'h1F3, 1'b0, 1'b0, 1'b1);
        expect_acc("b2b_second", 68, 70, 74, 10'h000, 10'h3FF, 1'b0, 1'b1, 1'b1);
        request(60, 20'h549F3, 1'b0, 1'b0, 1'b1);
        release_at(66);
        request(67, 20'h003FF, 1'b0, 1'b1, 1'b1);
        release_at(74);

        // Early AS_n release: CAS still held for two clocks.
        expect_acc("early_release", 90, 92, 94, 10'h3FF, 10'h000, 1'b0, 1'b0, 1'b0);
        request(90, 20'hFFC00, 1'b0, 1'b0, 1'b0);
        release_at(93);

        // Timer wrap at edge 390 coincides with a request.
        expect_ref("arb_refresh", 390, 391, 394);
        expect_acc("arb_access", 396, 398, 402, 10'h03C, 10'h0F0, 1'b0, 1'b0, 1'b1);
        request(390, 20'h0F0F0, 1'b0, 1'b0, 1'b1);
        for (int c = 390; c <= 395; c++) begin
            go_to(c);
            check("arb_no_dtack", DTACK_DRAM_n, 1);
        end
        release_at(402);

        // Stall in CAS across wraps at 780/1170/1560/1950: exactly three refreshes follow.
        expect_acc("stall_access", 410, 412, 1980, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1);
        expect_ref("sat_ref1", 1982, 1983, 1986);
        expect_ref("sat_ref2", 1988, 1989, 1992);
        expect_ref("sat_ref3", 1994, 1995, 1998);
        expect_acc("post_sat_probe", 2010, 2012, 2016, 10'h000, 10'h001, 1'b1, 1'b0, 1'b0);
        request(410, 20'hFFFFF, 1'b0, 1'b0, 1'b1);
        release_at(1980);
        request(2010, 20'h00001, 1'b1, 1'b0, 1'b0);
        release_at(2016);

        // Reset in the middle of CAS aborts the access at once.
        request(2030, 20'h55555, 1'b0, 1'b0, 1'b1);
        go_to(2033);
        check("pre_reset_in_cas", DTACK_DRAM_n, 0);
        #2 RST_n = 1'b0;
        #1 check_reset_outputs("reset_mid_cas");
        idle_bus();
        repeat (2) @(negedge CLK);
        #2 RST_n = 1'b1;
        expect_ref("first_refresh", 390, 391, 394);
        go_to(400);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
